prefetch_queue: RTL and testbench

- Parametrised instruction prefetch FIFO between the fetch stage and the instruction memory port.
- Streams sequential 32-bit words from imem into a tagged circular queue of 2**DEPTH_LOG entries.
- Serves 32-bit and 16-bit (compressed) instructions at any halfword address, including instructions that straddle two words.
- Redirects on miss; invalidates and issues imem fence on request.

---
 rtl/prefetch_queue.sv | 238 +++++++++++++++++++++++
 tb/tb_prefetch_queue.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch FIFO between the fetch stage and imem.
//
// Streams sequential words from imem into a tagged circular queue of
// 2**DEPTH_LOG entries ({addr[31:2], data}) and serves 16-bit and 32-bit
// instructions at any halfword address, including ones that straddle two
// words. A miss redirects the fetch stream; a fence request flushes the queue
// and issues an imem fence.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   defined   - a response arriving this cycle is visible to the hit logic as
//               if it were already stored at the tail.
//   undefined - only stored entries can hit.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pf_valid, pf_fence       fetch request / fence request (with pf_valid)
//   pf_addr[31:0]            requested PC, halfword aligned
//   pf_rdata[31:0], pf_ready instruction (upper half zero if compressed), hit
//   imem_valid, imem_fence   registered request / fence request
//   imem_instr, imem_wdata,  constant 1 / 0 / 0
//   imem_wstrb
//   imem_addr[31:0]          registered word address
//   imem_rdata, imem_ready   response data / response or fence done
module prefetch_queue #(
    parameter int unsigned DEPTH_LOG  = 3,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pf_valid,
    input  logic        pf_fence,
    input  logic [31:0] pf_addr,
    output logic [31:0] pf_rdata,
    output logic        pf_ready,
    output logic        imem_valid,
    output logic        imem_fence,
    output logic        imem_instr,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [3:0]  imem_wstrb,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] CNT_ONE  = {{DEPTH_LOG{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG:0] CNT_FULL = {1'b1, {DEPTH_LOG{1'b0}}};

    typedef enum logic {RUN, FENCE} state_t;

    state_t               state;
    logic [29:0]          tag_mem  [DEPTH];
    logic [31:0]          data_mem [DEPTH];
    logic [DEPTH_LOG-1:0] head, tail, head_nx1;
    logic [DEPTH_LOG:0]   count, count_nxt;
    logic [29:0]          faddr, faddr_eff, fence_addr;
    logic                 discard, fence_pend;

    logic [29:0] word, word_p1;
    logic        rsp_done, rsp_ok, busy, active, fence_req, lookup;
    logic        fence_want, fence_go, fence_done, flush, push, issue;
    logic        pend_w, pend_w1;

    logic        h_v, n_v, hit, pop, miss;
    logic [29:0] h_tag, n_tag;
    logic [31:0] h_data, n_data, rdata;

    logic        unused_bits;

    assign imem_instr  = 1'b1;
    assign imem_wdata  = '0;
    assign imem_wstrb  = '0;
    assign unused_bits = ^{pf_addr[0], n_data[31:16]};

    assign word     = pf_addr[31:2];
    assign word_p1  = word + 30'd1;
    assign head_nx1 = head + 1'b1;

    assign rsp_done  = imem_valid && imem_ready;
    assign rsp_ok    = rsp_done && !imem_fence && !discard && (state == RUN);
    assign busy      = imem_valid && !imem_ready;
    // Requests are ignored while a fence is waiting for the bus to drain.
    assign active    = pf_valid && !rst && (state == RUN) && !fence_pend;
    assign fence_req = active && pf_fence;
    assign lookup    = active && !pf_fence;

    // A word counts as "on its way" only if the outstanding request will be kept.
    assign pend_w  = imem_valid && !imem_fence && !discard && (imem_addr[31:2] == word);
    assign pend_w1 = imem_valid && !imem_fence && !discard && (imem_addr[31:2] == word_p1);

    always_comb begin
        h_v    = (count != '0);
        h_tag  = tag_mem[head];
        h_data = data_mem[head];
        n_v    = (count > CNT_ONE);
        n_tag  = tag_mem[head_nx1];
        n_data = data_mem[head_nx1];
`ifdef PREFETCH_BYPASS_EN
        if (rsp_ok && (count == '0)) begin
            h_v    = 1'b1;
            h_tag  = imem_addr[31:2];
            h_data = imem_rdata;
        end
        if (rsp_ok && (count == CNT_ONE)) begin
            n_v    = 1'b1;
            n_tag  = imem_addr[31:2];
            n_data = imem_rdata;
        end
`endif
    end

    always_comb begin
        hit   = 1'b0;
        pop   = 1'b0;
        miss  = 1'b0;
        rdata = '0;
        if (lookup) begin
            if (h_v && (h_tag == word)) begin
                if (!pf_addr[1]) begin
                    hit = 1'b1;
                    if (h_data[1:0] != 2'b11) begin
                        rdata = {16'h0, h_data[15:0]};
                    end else begin
                        rdata = h_data;
                        pop   = 1'b1;
                    end
                end else if (h_data[17:16] != 2'b11) begin
                    hit   = 1'b1;
                    pop   = 1'b1;
                    rdata = {16'h0, h_data[31:16]};
                end else if (n_v && (n_tag == word_p1)) begin
                    // Straddle: only the head is consumed; head+1 keeps its low parcel's word.
                    hit   = 1'b1;
                    pop   = 1'b1;
                    rdata = {n_data[15:0], h_data[31:16]};
                end else if (!(!n_v && pend_w1)) begin
                    miss = 1'b1;
                end
            end else if (!(!h_v && pend_w)) begin
                miss = 1'b1;
            end
        end
    end

    assign pf_ready = hit;
    assign pf_rdata = rdata;

    assign flush = miss || fence_req;
    assign push  = rsp_ok && !flush;

    always_comb begin
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
        if (flush) count_nxt = '0;
    end

    assign fence_done = (state == FENCE) && imem_ready;
    assign fence_want = fence_pend || fence_req;
    assign fence_go   = (state == RUN) && fence_want && !busy;
    assign faddr_eff  = fence_done ? fence_addr : (miss ? word : faddr);
    // The slot for a new response is reserved at issue time, so a push can never overflow.
    assign issue      = (((state == RUN) && !fence_want && !busy) || fence_done) &&
                        (count_nxt < CNT_FULL);

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[tail]  <= imem_addr[31:2];
            data_mem[tail] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            faddr      <= RESET_ADDR[31:2];
            fence_addr <= '0;
            discard    <= 1'b0;
            fence_pend <= 1'b0;
            imem_valid <= 1'b0;
            imem_fence <= 1'b0;
            imem_addr  <= '0;
        end else begin
            count <= count_nxt;
            if (flush)     head <= tail;
            else if (pop)  head <= head_nx1;
            if (push)      tail <= tail + 1'b1;

            // A response completing in the flush cycle is simply not pushed.
            if (flush)         discard <= busy;
            else if (rsp_done) discard <= 1'b0;

            if (fence_req) begin
                fence_pend <= 1'b1;
                fence_addr <= word;
            end

            unique case (state)
                RUN: begin
                    if (fence_go) begin
                        state      <= FENCE;
                        imem_valid <= 1'b1;
                        imem_fence <= 1'b1;
                        imem_addr  <= {faddr, 2'b00};
                        fence_pend <= 1'b0;
                    end else if (issue) begin
                        imem_valid <= 1'b1;
                        imem_addr  <= {faddr_eff, 2'b00};
                        faddr      <= faddr_eff + 30'd1;
                    end else begin
                        if (rsp_done) imem_valid <= 1'b0;
                        if (miss)     faddr      <= word;
                    end
                end
                FENCE: begin
                    if (imem_ready) begin
                        state      <= RUN;
                        imem_fence <= 1'b0;
                        if (issue) begin
                            imem_valid <= 1'b1;
                            imem_addr  <= {faddr_eff, 2'b00};
                            faddr      <= faddr_eff + 30'd1;
                        end else begin
                            imem_valid <= 1'b0;
                            faddr      <= fence_addr;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed, table-driven bench for prefetch_queue
// (DEPTH_LOG=2, RESET_ADDR=0x100) with a one-cycle-latency imem responder.
module tb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pf_valid = 1'b0;
    logic        pf_fence = 1'b0;
    logic [31:0] pf_addr = '0;
    logic [31:0] pf_rdata;
    logic        pf_ready;
    logic        imem_valid, imem_fence, imem_instr;
    logic [31:0] imem_addr, imem_wdata;
    logic [3:0]  imem_wstrb;
    logic [31:0] imem_rdata = '0;
    logic        imem_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic        hold_en    = 1'b0;
    logic [31:0] hold_addr  = '0;
    logic        hold_fence = 1'b0;
    logic [31:0] log_addr [$];
    logic        log_fence[$];

    prefetch_queue #(.DEPTH_LOG(2), .RESET_ADDR(32'h100)) dut (
        .clk(clk), .rst(rst),
        .pf_valid(pf_valid), .pf_fence(pf_fence), .pf_addr(pf_addr),
        .pf_rdata(pf_rdata), .pf_ready(pf_ready),
        .imem_valid(imem_valid), .imem_fence(imem_fence), .imem_instr(imem_instr),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0000_0013;
            32'h104: return 32'h0000_0093;
            32'h108: return 32'h0000_0113;
            32'h10C: return 32'h0000_0193;
            32'h200: return 32'h4501_4581;
            32'h300: return 32'h0013_0001;
            32'h304: return 32'hABCD_0000;
            32'h400: return 32'h00A0_0093;
            32'h800: return 32'h1234_5677;
            default: return {a[15:0], 16'hBEEF};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits until the queue serves pf_addr, bounded; a timeout shows up as pf_ready=0.
    task automatic wait_hit(input logic [31:0] a);
        int unsigned n;
        n = 0;
        pf_valid = 1'b1;
        pf_fence = 1'b0;
        pf_addr  = a;
        #2;
        while (!pf_ready && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
    endtask

    // imem responder: answers each request one cycle after it appears.
    initial begin
        forever begin
            @(negedge clk);
            if (imem_ready) begin
                imem_ready = 1'b0;
            end else if (imem_valid === 1'b1 &&
                         !(hold_en && !imem_fence && imem_addr == hold_addr) &&
                         !(hold_fence && imem_fence)) begin
                imem_ready = 1'b1;
                imem_rdata = imem_fence ? 32'h0 : mem_word(imem_addr);
                log_addr.push_back(imem_addr);
                log_fence.push_back(imem_fence);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        valid;
        logic        wait_hit;
        logic [31:0] addr;
        logic        exp_ready;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int unsigned n;
        int unsigned fsz;

        vecs[0] = '{1'b1, 1'b0, 32'h104, 1'b1, 32'h0000_0093};
        vecs[1] = '{1'b0, 1'b0, 32'h108, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h108, 1'b1, 32'h0000_0113};
        vecs[3] = '{1'b1, 1'b0, 32'h200, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h0000_4581};
        vecs[5] = '{1'b1, 1'b0, 32'h200, 1'b1, 32'h0000_4581};
        vecs[6] = '{1'b1, 1'b0, 32'h202, 1'b1, 32'h0000_4501};
        vecs[7] = '{1'b1, 1'b0, 32'h302, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b1, 1'b1, 32'h302, 1'b1, 32'h0000_0013};
        vecs[9] = '{1'b1, 1'b0, 32'h306, 1'b1, 32'h0000_ABCD};

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_pf_ready",   {31'b0, pf_ready},   32'h0);
        check("rst_pf_rdata",   pf_rdata,            32'h0);
        check("rst_imem_valid", {31'b0, imem_valid}, 32'h0);
        check("rst_imem_fence", {31'b0, imem_fence}, 32'h0);
        check("const_instr",    {31'b0, imem_instr}, 32'h1);
        check("const_wstrb",    {28'b0, imem_wstrb}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        log_addr.delete();
        log_fence.delete();
        #2;
        check("pre_issue_valid", {31'b0, imem_valid}, 32'h0);
        @(negedge clk);
        #2;
        check("first_req_valid", {31'b0, imem_valid}, 32'h1);
        check("first_req_addr",  imem_addr,           32'h100);

        // Fill: exactly four words, then no further requests
        repeat (20) @(negedge clk);
        #2;
        check("fill_count", log_addr.size(), 32'd4);
        for (int unsigned i = 0; i < 4; i++)
            if (i < log_addr.size())
                check($sformatf("fill_addr%0d", i), log_addr[i], 32'h100 + 4 * i);
        check("fill_idle", {31'b0, imem_valid}, 32'h0);

        // One pop releases exactly one new request
        @(negedge clk);
        pf_valid = 1'b1;
        pf_addr  = 32'h100;
        #2;
        check("pop_ready", {31'b0, pf_ready}, 32'h1);
        check("pop_rdata", pf_rdata,          32'h13);
        @(negedge clk);
        pf_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        check("refill_count", log_addr.size(), 32'd5);
        if (log_addr.size() >= 5) check("refill_addr", log_addr[4], 32'h110);
        check("refill_idle", {31'b0, imem_valid}, 32'h0);

        // Table-driven hits, compressed pair and straddle
        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vecs[i].wait_hit) begin
                wait_hit(vecs[i].addr);
            end else begin
                pf_valid = vecs[i].valid;
                pf_fence = 1'b0;
                pf_addr  = vecs[i].addr;
                #2;
            end
            check($sformatf("vec%0d_ready", i), {31'b0, pf_ready}, {31'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d_rdata", i), pf_rdata, vecs[i].exp_rdata);
        end
        @(negedge clk);
        pf_valid = 1'b0;

        // Mid-stream reset, then a miss while 0x10C is outstanding
        hold_en   = 1'b1;
        hold_addr = 32'h10C;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        log_addr.delete();
        log_fence.delete();
        n = 0;
        #2;
        while (!(imem_valid && imem_addr == 32'h10C) && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("disc_outstanding", imem_addr, 32'h10C);
        @(negedge clk);
        pf_valid = 1'b1;
        pf_addr  = 32'h800;
        #2;
        check("miss_ready", {31'b0, pf_ready}, 32'h0);
        @(negedge clk);
        pf_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("held_valid", {31'b0, imem_valid}, 32'h1);
        check("held_addr",  imem_addr,           32'h10C);
        hold_en = 1'b0;
        @(negedge clk);
        wait_hit(32'h800);
        check("redir_ready", {31'b0, pf_ready}, 32'h1);
        check("redir_rdata", pf_rdata,          32'h1234_5677);
        @(negedge clk);
        pf_valid = 1'b0;
        check("redir_log_size", {31'b0, log_addr.size() >= 5}, 32'h1);
        if (log_addr.size() >= 5) begin
            check("redir_log_10c", log_addr[3], 32'h10C);
            check("redir_log_800", log_addr[4], 32'h800);
        end

        // Fence
        hold_fence = 1'b1;
        pf_valid   = 1'b1;
        pf_fence   = 1'b1;
        pf_addr    = 32'h400;
        #2;
        check("fence_req_ready", {31'b0, pf_ready}, 32'h0);
        @(negedge clk);
        pf_valid = 1'b0;
        pf_fence = 1'b0;
        n = 0;
        #2;
        while (!imem_fence && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("fence_active", {31'b0, imem_fence}, 32'h1);
        check("fence_valid",  {31'b0, imem_valid}, 32'h1);
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            pf_valid = 1'b1;
            pf_addr  = 32'h400;
            #2;
            check($sformatf("fence_ignore%0d", i), {31'b0, pf_ready}, 32'h0);
        end
        check("fence_held", {31'b0, imem_fence}, 32'h1);
        @(negedge clk);
        pf_valid   = 1'b0;
        fsz        = log_addr.size();
        hold_fence = 1'b0;
        n = 0;
        while (log_addr.size() < fsz + 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("post_fence_log", {31'b0, log_addr.size() >= fsz + 2}, 32'h1);
        if (log_addr.size() >= fsz + 2) begin
            check("fence_logged",   {31'b0, log_fence[fsz]},     32'h1);
            check("post_fence_addr", log_addr[fsz + 1],          32'h400);
            check("post_fence_nf",  {31'b0, log_fence[fsz + 1]}, 32'h0);
        end
        @(negedge clk);
        wait_hit(32'h400);
        check("fence_hit_ready", {31'b0, pf_ready}, 32'h1);
        check("fence_hit_rdata", pf_rdata,          32'h00A0_0093);
        @(negedge clk);
        pf_addr = 32'h804;
        #2;
        check("fence_flushed", {31'b0, pf_ready}, 32'h0);
        @(negedge clk);
        pf_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
